pcs_tx_frame_gen: RTL

//  Frame source for the PCS TX client interface: drives the pcs_tx block-level inputs
//  (ctrl/idle/start/term/err/keep/data) with complete Ethernet frames in place of the RX loopback.
//  On request it emits one start block with preamble/SFD, N data blocks of counting payload, one

---
 rtl/pcs_tx_frame_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pcs_tx_frame_gen.sv
// Frame source for the pcs_tx client interface: start block, counting payload, term block and
// an idle gap, every block advancing only when pcs_tx signals ready.
module pcs_tx_frame_gen #(
   parameter int  IS_10G      = 1,
   parameter int  DATA_W      = 64,
   parameter int  LEN_W       = 16,
   parameter int  IPG_BLK     = 2,
   parameter int  CNT_W       = 32,
   localparam int KEEP_W      = DATA_W / 8,
   localparam int LANE0_CNT_N = (IS_10G != 0) ? 2 : 1
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   ready_i,
   input  logic                   req_v_i,
   output logic                   req_rdy_o,
   input  logic [LEN_W-1:0]       req_len_i,
   input  logic [7:0]             req_seed_i,
   input  logic                   req_err_i,
   output logic                   ctrl_v_o,
   output logic                   idle_v_o,
   output logic [LANE0_CNT_N-1:0] start_v_o,
   output logic                   term_v_o,
   output logic                   err_v_o,
   output logic [KEEP_W-1:0]      keep_o,
   output logic [DATA_W-1:0]      data_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [CNT_W-1:0]       frame_cnt_o,
   output logic [2:0]             dbg_state_o
);

   // Handshake: the registered block on the outputs is consumed at a posedge where ready_i=1,
   // and only then does the next block get loaded; a request is taken at such an edge while
   // req_rdy_o=1, req_v_i=1 and req_len_i!=0.

   localparam int IPG_W = $clog2(IPG_BLK + 1);
   localparam int REM_W = $clog2(KEEP_W);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_TERM, ST_IPG} state_e;

   state_e                 state_q, state_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic [7:0]             seed_q, seed_d;
   logic                   err_q, err_d;
   logic [LEN_W-1:0]       idx_q, idx_d;
   logic [IPG_W-1:0]       ipg_cnt_q, ipg_cnt_d;
   logic                   ctrl_v_q, ctrl_v_d;
   logic                   idle_v_q, idle_v_d;
   logic [LANE0_CNT_N-1:0] start_v_q, start_v_d;
   logic                   term_v_q, term_v_d;
   logic                   err_v_q, err_v_d;
   logic [KEEP_W-1:0]      keep_q, keep_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   done_q, done_d;
   logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;

   logic                   full_fits;
   logic [REM_W-1:0]       rem;
   logic [KEEP_W-1:0]      term_keep;

   // Byte j of a block carries seed + byte offset + j, zero where keep is clear.
   function automatic logic [DATA_W-1:0] payload(input logic [7:0] seed,
                                                 input logic [7:0] off,
                                                 input logic [KEEP_W-1:0] keep);
      logic [DATA_W-1:0] d;
      logic [7:0]        base;
      d    = '0;
      base = seed + off;
      for (int j = 0; j < KEEP_W; j++) begin
         if (keep[j]) d[8*j +: 8] = base + 8'(j);
      end
      return d;
   endfunction

   assign full_fits = ({1'b0, idx_q} + (LEN_W+1)'(KEEP_W)) <= {1'b0, len_q};
   assign rem       = len_q[REM_W-1:0];
   assign term_keep = KEEP_W'((32'd1 << rem) - 32'd1);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      seed_d      = seed_q;
      err_d       = err_q;
      idx_d       = idx_q;
      ipg_cnt_d   = ipg_cnt_q;
      ctrl_v_d    = ctrl_v_q;
      idle_v_d    = idle_v_q;
      start_v_d   = start_v_q;
      term_v_d    = term_v_q;
      err_v_d     = err_v_q;
      keep_d      = keep_q;
      data_d      = data_q;
      frame_cnt_d = frame_cnt_q;
      done_d      = 1'b0;
      if (ready_i) begin
         ctrl_v_d  = 1'b1;
         idle_v_d  = 1'b1;
         start_v_d = '0;
         term_v_d  = 1'b0;
         err_v_d   = 1'b0;
         keep_d    = '0;
         data_d    = '0;
         case (state_q)
            ST_IDLE: begin
               if (req_v_i && (req_len_i != '0)) begin
                  len_d     = req_len_i;
                  seed_d    = req_seed_i;
                  err_d     = req_err_i;
                  idx_d     = '0;
                  state_d   = ST_START;
                  idle_v_d  = 1'b0;
                  start_v_d = LANE0_CNT_N'(1);
                  keep_d    = '1;
                  data_d    = 64'hD555_5555_5555_5555;
               end
            end
            // The start block shares the data path with idx_q still at zero.
            ST_START, ST_DATA: begin
               idle_v_d = 1'b0;
               if (full_fits) begin
                  ctrl_v_d = 1'b0;
                  keep_d   = '1;
                  data_d   = payload(seed_q, idx_q[7:0], '1);
                  idx_d    = idx_q + LEN_W'(KEEP_W);
                  state_d  = ST_DATA;
               end else begin
                  term_v_d = 1'b1;
                  err_v_d  = err_q;
                  keep_d   = term_keep;
                  data_d   = payload(seed_q, idx_q[7:0], term_keep);
                  state_d  = ST_TERM;
               end
            end
            // The last gap block is presented from IDLE so a held request makes the gap exact.
            ST_TERM: begin
               done_d      = 1'b1;
               frame_cnt_d = frame_cnt_q + 1'b1;
               ipg_cnt_d   = IPG_W'(1);
               state_d     = (IPG_BLK <= 1) ? ST_IDLE : ST_IPG;
            end
            ST_IPG: begin
               ipg_cnt_d = ipg_cnt_q + 1'b1;
               if (ipg_cnt_q >= IPG_W'(IPG_BLK - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         seed_q      <= '0;
         err_q       <= 1'b0;
         idx_q       <= '0;
         ipg_cnt_q   <= '0;
         ctrl_v_q    <= 1'b1;
         idle_v_q    <= 1'b1;
         start_v_q   <= '0;
         term_v_q    <= 1'b0;
         err_v_q     <= 1'b0;
         keep_q      <= '0;
         data_q      <= '0;
         done_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         seed_q      <= seed_d;
         err_q       <= err_d;
         idx_q       <= idx_d;
         ipg_cnt_q   <= ipg_cnt_d;
         ctrl_v_q    <= ctrl_v_d;
         idle_v_q    <= idle_v_d;
         start_v_q   <= start_v_d;
         term_v_q    <= term_v_d;
         err_v_q     <= err_v_d;
         keep_q      <= keep_d;
         data_q      <= data_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign req_rdy_o   = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign ctrl_v_o    = ctrl_v_q;
   assign idle_v_o    = idle_v_q;
   assign start_v_o   = start_v_q;
   assign term_v_o    = term_v_q;
   assign err_v_o     = err_v_q;
   assign keep_o      = keep_q;
   assign data_o      = data_q;
   assign done_o      = done_q;
   assign frame_cnt_o = frame_cnt_q;
   assign dbg_state_o = state_q;

endmodule
